// File: rtl/pwm_reg_arbiter.sv
// pwm_reg_arbiter: two-requester arbiter turning 8/16-bit commands into byte register-file strobes; PWM_ARB_ROUND_ROBIN_EN selects alternating ties.
// Latency grant->ack: 8-bit write 2, 16-bit write 3, 8-bit read 3, 16-bit read 4 cycles.
// Backpressure: a request is held until its ack; requests seen while busy wait for IDLE.
module pwm_reg_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        rw0,
    input  logic        wide0,
    input  logic [5:0]  addr0,
    input  logic [15:0] wdata0,
    output logic        ack0,
    output logic [15:0] rdata0,
    input  logic        req1,
    input  logic        rw1,
    input  logic        wide1,
    input  logic [5:0]  addr1,
    input  logic [15:0] wdata1,
    output logic        ack1,
    output logic [15:0] rdata1,
    output logic        rf_read,
    output logic        rf_write,
    output logic [5:0]  rf_addr,
    output logic [7:0]  rf_wdata,
    input  logic [7:0]  rf_rdata,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, LSB, MSB, CAP, ACK} state_t;

    state_t      state, state_nxt;
    logic        gnt;
    logic        pick;
    logic        cmd_rw;
    logic        cmd_wide;
    logic [5:0]  cmd_addr;
    logic [15:0] cmd_wdata;
    logic [7:0]  rbuf;
    logic [15:0] cap_word;

`ifdef PWM_ARB_ROUND_ROBIN_EN
    logic rr_ptr;   // requester that wins the next tie
    assign pick = (req0 && req1) ? rr_ptr : req1;
`else
    assign pick = !req0;
`endif

    assign busy     = (state != IDLE);
    assign cap_word = cmd_wide ? {rf_rdata, rbuf} : {8'h00, rf_rdata};

    always_comb begin
        state_nxt = state;
        rf_read   = 1'b0;
        rf_write  = 1'b0;
        rf_addr   = '0;
        rf_wdata  = '0;
        ack0      = 1'b0;
        ack1      = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) state_nxt = LSB;
            end
            LSB: begin
                rf_read   = !cmd_rw;
                rf_write  = cmd_rw;
                rf_addr   = cmd_addr;
                rf_wdata  = cmd_rw ? cmd_wdata[7:0] : 8'h00;
                state_nxt = cmd_wide ? MSB : (cmd_rw ? ACK : CAP);
            end
            MSB: begin
                rf_read   = !cmd_rw;
                rf_write  = cmd_rw;
                rf_addr   = cmd_addr + 6'd1;    // wraps 3F -> 00
                rf_wdata  = cmd_rw ? cmd_wdata[15:8] : 8'h00;
                state_nxt = cmd_rw ? ACK : CAP;
            end
            CAP: begin
                state_nxt = ACK;
            end
            ACK: begin
                ack0      = !gnt;
                ack1      = gnt;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state     <= IDLE;
            gnt       <= 1'b0;
            cmd_rw    <= 1'b0;
            cmd_wide  <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            rbuf      <= '0;
            rdata0    <= '0;
            rdata1    <= '0;
`ifdef PWM_ARB_ROUND_ROBIN_EN
            rr_ptr    <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (state == IDLE && (req0 || req1)) begin
                gnt       <= pick;
                cmd_rw    <= pick ? rw1    : rw0;
                cmd_wide  <= pick ? wide1  : wide0;
                cmd_addr  <= pick ? addr1  : addr0;
                cmd_wdata <= pick ? wdata1 : wdata0;
`ifdef PWM_ARB_ROUND_ROBIN_EN
                rr_ptr    <= !pick;
`endif
            end
            // MSB-state read captures the low byte returned for the LSB strobe
            if (state == MSB && !cmd_rw) rbuf <= rf_rdata;
            if (state == CAP) begin
                if (gnt) rdata1 <= cap_word;
                else     rdata0 <= cap_word;
            end
        end
    end

endmodule

// File: tb/tb_pwm_reg_arbiter.sv
// Bench for pwm_reg_arbiter: transaction-level model with per-cycle output compare plus directed literal checks.
`timescale 1ns/1ps
module tb_pwm_reg_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req0, rw0, wide0, req1, rw1, wide1;
    logic [5:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        ack0, ack1;
    logic [15:0] rdata0, rdata1;
    logic        rf_read, rf_write, busy;
    logic [5:0]  rf_addr;
    logic [7:0]  rf_wdata, rf_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    pwm_reg_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .rw0(rw0), .wide0(wide0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .rw1(rw1), .wide1(wide1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
        .rf_read(rf_read), .rf_write(rf_write), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
        .rf_rdata(rf_rdata), .busy(busy)
    );

    function automatic logic [7:0] init_val(input int a);
        case (a)
            0:       return 8'h34;
            1:       return 8'h12;
            5:       return 8'hC3;
            default: return 8'(a * 7 + 64);
        endcase
    endfunction

    // Register-file stub with registered read data
    logic [7:0]  rf_mem [64];
    logic [63:0] rf_seen = '0;
    always @(posedge clk) begin
        if (rf_write) begin
            rf_mem[rf_addr]  <= rf_wdata;
            rf_seen[rf_addr] <= 1'b1;
        end
        if (rf_read) rf_rdata <= rf_seen[rf_addr] ? rf_mem[rf_addr] : init_val(int'(rf_addr));
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: each granted command expands into one expected record per following cycle
    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [5:0]  addr;
        logic [7:0]  wd;
        logic [1:0]  ack;     // bit0 = ack0, bit1 = ack1
        logic        set_rd;
        logic        port;
        logic [15:0] rv;
    } exp_t;

    exp_t mq[$];

    initial begin : model
        logic [7:0]  sh [64];
        logic [15:0] ex_rd [2];
        logic        last_g, g, rw, wide, was_idle;
        logic [5:0]  a, a1;
        logic [15:0] wd;
        exp_t        e, r;
        for (int i = 0; i < 64; i++) sh[i] = init_val(i);
        ex_rd[0] = '0;
        ex_rd[1] = '0;
        last_g   = 1'b1;
        @(posedge clk);
        forever begin
            @(negedge clk);
            was_idle = (mq.size() == 0);
            e = '0;
            if (!was_idle) e = mq.pop_front();
            if (e.set_rd) ex_rd[e.port] = e.rv;
            if (e.wr) sh[e.addr] = e.wd;
            check("cycle",
                  {busy, rf_read, rf_write, rf_addr, rf_wdata, ack1, ack0, rdata0, rdata1},
                  {!was_idle, e.rd, e.wr, e.addr, e.wd, e.ack, ex_rd[0], ex_rd[1]});
            if (rst_n) begin
                mq.delete();
                ex_rd[0] = '0;
                ex_rd[1] = '0;
                last_g   = 1'b1;
            end else if (was_idle && (req0 || req1)) begin
`ifdef PWM_ARB_ROUND_ROBIN_EN
                if (req0 && req1) g = !last_g;
                else              g = req1;
`else
                g = req0 ? 1'b0 : 1'b1;
`endif
                last_g = g;
                rw   = g ? rw1    : rw0;
                wide = g ? wide1  : wide0;
                a    = g ? addr1  : addr0;
                wd   = g ? wdata1 : wdata0;
                a1   = 6'((int'(a) + 1) % 64);
                r = '0; r.rd = !rw; r.wr = rw; r.addr = a; r.wd = rw ? wd[7:0] : 8'h00;
                mq.push_back(r);
                if (wide) begin
                    r = '0; r.rd = !rw; r.wr = rw; r.addr = a1; r.wd = rw ? wd[15:8] : 8'h00;
                    mq.push_back(r);
                end
                if (!rw) begin
                    r = '0;
                    mq.push_back(r);
                end
                r = '0;
                r.ack = g ? 2'b10 : 2'b01;
                r.set_rd = !rw;
                r.port = g;
                r.rv = wide ? {sh[a1], sh[a]} : {8'h00, sh[a]};
                mq.push_back(r);
            end
        end
    end

    logic [15:0] lg[$];   // {rf_write, rf_read, rf_addr, rf_wdata} per strobe

    function automatic logic [15:0] lg_at(input int i);
        return (lg.size() > i) ? lg[i] : 16'hFFFF;
    endfunction

    task automatic run_cmd(input bit p, input bit rw, input bit wide, input logic [5:0] a,
                           input logic [15:0] wd, output int lat);
        lg.delete();
        lat = -1;
        @(posedge clk); #1;
        if (p) begin rw1 = rw; wide1 = wide; addr1 = a; wdata1 = wd; req1 = 1'b1; end
        else   begin rw0 = rw; wide0 = wide; addr0 = a; wdata0 = wd; req0 = 1'b1; end
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (rf_read || rf_write) lg.push_back({rf_write, rf_read, rf_addr, rf_wdata});
            if ((p ? ack1 : ack0) === 1'b1) begin
                lat = c;
                break;
            end
            if (c == 1) begin
                if (p) begin rw1 = !rw; wide1 = !wide; addr1 = ~a; wdata1 = ~wd; end
                else   begin rw0 = !rw; wide0 = !wide; addr0 = ~a; wdata0 = ~wd; end
            end
        end
        @(posedge clk); #1;
        if (p) req1 = 1'b0;
        else   req0 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int         lat, nack, got;
        logic [3:0] ord;
        {req0, rw0, wide0, addr0, wdata0} = '0;
        {req1, rw1, wide1, addr1, wdata1} = '0;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("reset_state", {busy, ack0, ack1, rf_read, rf_write, rf_addr, rf_wdata, rdata0, rdata1}, 0);
        @(posedge clk); #1 rst_n = 1'b0;

        run_cmd(0, 1, 1, 6'h03, 16'hA55A, lat);
        check("w16_lat", 64'(lat), 3);
        check("w16_nstb", 64'(lg.size()), 2);
        check("w16_stb0", lg_at(0), {2'b10, 6'h03, 8'h5A});
        check("w16_stb1", lg_at(1), {2'b10, 6'h04, 8'hA5});

        run_cmd(1, 0, 1, 6'h00, 16'h0000, lat);
        check("r16_lat", 64'(lat), 4);
        check("r16_rdata1", rdata1, 16'h1234);
        check("r16_stb0", lg_at(0), {2'b01, 6'h00, 8'h00});
        check("r16_stb1", lg_at(1), {2'b01, 6'h01, 8'h00});

        run_cmd(0, 1, 1, 6'h3F, 16'hBEEF, lat);
        check("wrap_lat", 64'(lat), 3);
        check("wrap_stb0", lg_at(0), {2'b10, 6'h3F, 8'hEF});
        check("wrap_stb1", lg_at(1), {2'b10, 6'h00, 8'hBE});

        run_cmd(1, 0, 1, 6'h3F, 16'h0000, lat);
        check("wrap_rd_lat", 64'(lat), 4);
        check("wrap_rd_rdata1", rdata1, 16'hBEEF);

        run_cmd(0, 0, 0, 6'h05, 16'h0000, lat);
        check("r8_lat", 64'(lat), 3);
        check("r8_rdata0", rdata0, 16'h00C3);
        check("r8_nstb", 64'(lg.size()), 1);

        run_cmd(1, 1, 0, 6'h10, 16'hFF77, lat);
        check("w8_lat", 64'(lat), 2);
        check("w8_stb0", lg_at(0), {2'b10, 6'h10, 8'h77});
        check("w8_nstb", 64'(lg.size()), 1);

        run_cmd(0, 0, 0, 6'h10, 16'h0000, lat);
        check("w8_readback", rdata0, 16'h0077);
        check("rdata1_held", rdata1, 16'hBEEF);

        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        check("reset_rdata", {rdata0, rdata1}, 0);

        // Both requesters held together
        @(posedge clk); #1;
        rw0 = 1'b1; wide0 = 1'b0; addr0 = 6'h20; wdata0 = 16'h0011;
        rw1 = 1'b1; wide1 = 1'b0; addr1 = 6'h21; wdata1 = 16'h0022;
        req0 = 1'b1; req1 = 1'b1;
        nack = 0;
        ord  = '0;
        for (int c = 0; c < 60 && nack < 4; c++) begin
            @(negedge clk);
            if (ack0) begin ord[nack] = 1'b0; nack++; end
            else if (ack1) begin ord[nack] = 1'b1; nack++; end
        end
        @(posedge clk); #1 req0 = 1'b0;
        check("tie_nack", 64'(nack), 4);
`ifdef PWM_ARB_ROUND_ROBIN_EN
        check("tie_order", ord, 4'b1010);
`else
        check("tie_order", ord, 4'b0000);
`endif
        got = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (ack1) begin got = 1; break; end
        end
        @(posedge clk); #1 req1 = 1'b0;
        check("held_req1_served", 64'(got), 1);

        // Reset during the MSB cycle of a 16-bit write
        @(posedge clk); #1;
        rw0 = 1'b1; wide0 = 1'b1; addr0 = 6'h08; wdata0 = 16'h1234; req0 = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1 rst_n = 1'b1; req0 = 1'b0;
        @(negedge clk);
        check("abort_msb_stb", {rf_write, rf_addr, rf_wdata}, {1'b1, 6'h09, 8'h12});
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        check("abort_quiet", {busy, rf_read, rf_write, rf_addr, rf_wdata, ack0, ack1}, 0);
        nack = 0;
        repeat (6) begin
            @(negedge clk);
            if (ack0 || ack1 || rf_read || rf_write || busy) nack++;
        end
        check("abort_no_activity", 64'(nack), 0);

        run_cmd(1, 0, 1, 6'h08, 16'h0000, lat);
        check("post_abort_lat", 64'(lat), 4);
        check("post_abort_rdata1", rdata1, 16'h1234);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
